dsp_subtractor: RTL and testbench



---
 rtl/dsp_sub_pkg.sv | 10 +
 rtl/dsp_sub16.sv | 19 +
 rtl/dsp_subtractor.sv | 99 +++++++++
 tb/tb_dsp_subtractor.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dsp_sub_pkg.sv
// rtl/dsp_sub_pkg.sv - shared widths and word/slice types for the pipelined subtractor
package dsp_sub_pkg;

  localparam int DSPSUB_W       = 32;
  localparam int DSPSUB_SLICE_W = 16;

  typedef logic [DSPSUB_W-1:0]       word_t;
  typedef logic [DSPSUB_SLICE_W-1:0] slice_t;

endpackage

// File: rtl/dsp_sub16.sv
// rtl/dsp_sub16.sv - combinational 16-bit subtract with borrow-in and borrow-out
module dsp_sub16
  import dsp_sub_pkg::*;
(
  input  logic [DSPSUB_SLICE_W-1:0] a,
  input  logic [DSPSUB_SLICE_W-1:0] b,
  input  logic                      bin,
  output logic [DSPSUB_SLICE_W-1:0] d,
  output logic                      bout
);

  // One extra bit catches the borrow: a negative result wraps into the top bit.
  logic [DSPSUB_SLICE_W:0] diff;

  assign diff = {1'b0, a} - {1'b0, b} - {{DSPSUB_SLICE_W{1'b0}}, bin};
  assign d    = diff[DSPSUB_SLICE_W-1:0];
  assign bout = diff[DSPSUB_SLICE_W];

endmodule

// File: rtl/dsp_subtractor.sv
// rtl/dsp_subtractor.sv - two-stage 32-bit subtractor built from two 16-bit slices
// Flag outputs (borrow/overflow/zero) exist only when DSP_SUBTRACTOR_FLAGS_EN is defined.
module dsp_subtractor
  import dsp_sub_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DSPSUB_W-1:0] input1,
  input  logic [DSPSUB_W-1:0] input2,
  output logic [DSPSUB_W-1:0] out,
  output logic                out_valid,
  output logic                borrow,
  output logic                overflow,
  output logic                zero
);

  localparam int SW = DSPSUB_SLICE_W;

  slice_t lo_d;
  logic   lo_bout;

  slice_t s1_d_lo;
  logic   s1_b_lo;
  slice_t s1_a_hi;
  slice_t s1_b_hi;
  logic   s1_valid;

  slice_t hi_d;
  logic   hi_bout;
  word_t  result;

  dsp_sub16 u_lo (
    .a    (input1[SW-1:0]),
    .b    (input2[SW-1:0]),
    .bin  (1'b0),
    .d    (lo_d),
    .bout (lo_bout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_d_lo  <= '0;
      s1_b_lo  <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_d_lo  <= lo_d;
      s1_b_lo  <= lo_bout;
      s1_a_hi  <= input1[DSPSUB_W-1:SW];
      s1_b_hi  <= input2[DSPSUB_W-1:SW];
      s1_valid <= in_valid;
    end
  end

  // High slice consumes the low-slice borrow captured in S1.
  dsp_sub16 u_hi (
    .a    (s1_a_hi),
    .b    (s1_b_hi),
    .bin  (s1_b_lo),
    .d    (hi_d),
    .bout (hi_bout)
  );

  assign result = {hi_d, s1_d_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= result;
      out_valid <= s1_valid;
    end
  end

`ifdef DSP_SUBTRACTOR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      borrow   <= hi_bout;
      overflow <= (s1_a_hi[SW-1] ^ s1_b_hi[SW-1]) & (s1_a_hi[SW-1] ^ hi_d[SW-1]);
      zero     <= (result == '0);
    end
  end
`else
  logic unused_flags;

  assign unused_flags = hi_bout;
  assign borrow       = 1'b0;
  assign overflow     = 1'b0;
  assign zero         = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_subtractor.sv
// tb/tb_dsp_subtractor.sv - directed self-checking bench for dsp_subtractor
// Flag expectations follow DSP_SUBTRACTOR_FLAGS_EN; without it the flags must read 0.
module tb_dsp_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] out;
  logic        out_valid;
  logic        borrow;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int errors = 0;

`ifdef DSP_SUBTRACTOR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  dsp_subtractor dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .input1    (input1),
    .input2    (input2),
    .out       (out),
    .out_valid (out_valid),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [31:0] e_out,
                            input bit e_b, input bit e_o, input bit e_z);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".out"}, out, e_out);
    chk({tag, ".borrow"}, {31'd0, borrow}, {31'd0, e_b & FLAGS});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e_o & FLAGS});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e_z & FLAGS});
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    input1   = a;
    input2   = b;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_out;
    bit          e_b;
    bit          e_o;
    bit          e_z;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    chk("rst.out", out, 32'h0);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.flags", {29'd0, borrow, overflow, zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single op: 0 - 0, valid must not show after only one edge.
    drive(1'b1, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    chk("zero.early_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk_result("zero", 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("zero.valid_drop", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream with one idle slot in the middle.
    vecs.push_back('{1, 32'd10,         32'd9,          32'd1,          0, 0, 0});
    vecs.push_back('{1, 32'd4000,       32'd1000,       32'd3000,       0, 0, 0});
    vecs.push_back('{1, 32'd65536,      32'd65540,      32'hFFFFFFFC,   1, 0, 0});
    vecs.push_back('{1, 32'd256,        32'd65540,      32'hFFFF00FC,   1, 0, 0});
    vecs.push_back('{0, 32'h1234,       32'h1234,       32'h0,          0, 0, 1});
    vecs.push_back('{1, 32'd1265536,    32'd65540,      32'd1199996,    0, 0, 0});
    vecs.push_back('{1, 32'd10,         32'd11,         32'hFFFFFFFF,   1, 0, 0});
    vecs.push_back('{1, 32'h80000000,   32'd1,          32'h7FFFFFFF,   0, 1, 0});
    vecs.push_back('{1, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000,   1, 1, 0});
    vecs.push_back('{1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h0,          0, 0, 1});
    vecs.push_back('{1, 32'h00010000,   32'd1,          32'h0000FFFF,   0, 0, 0});

    for (int i = 0; i <= vecs.size(); i++) begin
      if (i < vecs.size()) drive(vecs[i].v, vecs[i].a, vecs[i].b);
      else drive(1'b0, 32'd0, 32'd0);
      @(negedge clk);
      if (i >= 1) begin
        if (vecs[i-1].v)
          chk_result($sformatf("vec%0d", i-1), vecs[i-1].e_out,
                     vecs[i-1].e_b, vecs[i-1].e_o, vecs[i-1].e_z);
        else
          chk($sformatf("vec%0d.idle_valid", i-1), {31'd0, out_valid}, 32'd0);
      end
    end
    @(negedge clk);
    chk("stream.drain_valid", {31'd0, out_valid}, 32'd0);

    // Reset with two ops in flight: outputs clear immediately, nothing stale after.
    drive(1'b1, 32'd5, 32'd9);
    @(negedge clk);
    drive(1'b1, 32'd100, 32'd1);
    @(negedge clk);
    chk_result("pre_rst", 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd7, 32'd7);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst.out", out, 32'h0);
    chk("midrst.valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.flags", {29'd0, borrow, overflow, zero}, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("postrst.stale%0d", k), {31'd0, out_valid}, 32'd0);
    end

    drive(1'b1, 32'd7, 32'd3);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    chk("postrst.early_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk_result("postrst", 32'd4, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
